midi_writer: RTL and testbench
==============================

Name: midi_writer

Overview:
- MIDI transmit path: serializes one channel-voice message per handshake onto a UART line (8N1, 31250 baud), LSB first, from the 100 MHz system clock.
- Mirror of the MIDI receive path. It uses the same status-nibble, data_byte1 and data_byte2 fields the reader produces, so reader output can be looped back or forwarded to an external synth or computer.
- Optional running-status compression omits a repeated status byte.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 31_250, MIDI line rate. Bit period BIT_CYCLES = CLK_FREQ/BAUD_RATE = 3200.
- RUNNING_STATUS, 1, when 1 a status byte equal to the last transmitted status byte is omitted.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- status_in  input  4  message type nibble (0x8..0xF).
- channel_in  input  4  MIDI channel 0..15.
- data_byte1_in  input  8  first data byte; bit 7 ignored.
- data_byte2_in  input  8  second data byte; bit 7 ignored.
- valid_in  input  1  message request.
- ready_out  output  1  high when a message can be accepted.
- tx_wire_out  output  1  UART line, idle high.
- busy_out  output  1  high while any frame is in flight.
- error_out  output  1  one-cycle pulse when a message is rejected.

Behaviour:
- Reset (rst_in low, asynchronous):
  - tx_wire_out=1, ready_out=0, busy_out=0, error_out=0.
  - FSM returns to IDLE; running-status register cleared to "none".
  - ready_out rises on the first clk_in edge after rst_in deasserts.
- Handshake:
  - Accept on a rising edge with valid_in && ready_out. All inputs are latched there.
  - ready_out=1 only in IDLE and drops the cycle after acceptance.
  - Inputs are ignored while ready_out=0. valid_in held high is simply accepted when ready returns.
- Message length, from status_in:
  - 0x8, 0x9, 0xA, 0xB, 0xE: 3 bytes.
  - 0xC, 0xD: 2 bytes.
  - 0x0..0x7 and 0xF: rejected. error_out pulses the cycle after acceptance, nothing is transmitted, ready_out returns 1 the following cycle, running status is unchanged.
- Byte assembly:
  - Status byte = {status_in, channel_in}.
  - Data bytes are sent with bit 7 forced to 0.
- Running status (RUNNING_STATUS=1):
  - If the status byte equals the stored last status, the status byte is skipped and only the data bytes are sent.
  - The stored status updates whenever a status byte is sent.
- FSM states and transitions:
  - IDLE -> LOAD (select next byte, apply the running-status skip) -> START -> DATA -> STOP.
  - START drives 0 for BIT_CYCLES.
  - DATA drives 8 bits, LSB first, BIT_CYCLES each.
  - STOP drives 1 for BIT_CYCLES.
  - From STOP: back to LOAD if bytes remain, else IDLE.
  - Bytes are back-to-back with no idle gap between stop and next start.
- Timing:
  - The start bit begins 2 cycles after the acceptance edge (one cycle in LOAD).
  - Frame = 10*BIT_CYCLES = 32000 cycles.
  - Message = N*32000 cycles plus 2 cycles of setup.
  - ready_out rises 1 cycle after the final stop bit ends.
- Counters:
  - Baud counter is clog2(BIT_CYCLES) bits and counts 0..BIT_CYCLES-1; it wraps only on bit boundaries.
  - Bit index is 0..7; byte index is 0..2.
- busy_out is high from the first LOAD through the final STOP.
- tx_wire_out is driven from a flop, so it is glitch-free.
- Reset mid-frame: line forced high immediately, partial byte abandoned, no resume.

Decomposition:
- Package midi_pkg:
  - Status-nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CHAN_AT=4'hD, PITCH=4'hE).
  - MIDI_BAUD constant.
  - msg_len(status) function returning 0, 2 or 3.
  - FSM state enum.
- One sub-module, uart_byte_tx:
  - 8N1 serializer with byte_in/valid_in/ready_out/done_out, parameterized by BIT_CYCLES.
  - midi_writer keeps the message sequencing and running-status logic.

Test Plan:
- Note-on, status 0x9, ch 0, d1 0x3C, d2 0x64 -> line decodes 0x90, 0x3C, 0x64. Each bit lasts 3200±0 cycles, total 96002 cycles accept-to-ready, busy_out high throughout.
- Program change, status 0xC, ch 5, d1 0x07, d2 0xFF -> only 0xC5 0x07 sent, 64002 cycles, d2 ignored.
- Running status:
  - Note-on ch 2 (0x3C,0x40) then note-on ch 2 (0x3E,0x40) -> second message sends 0x3E 0x40 only.
  - A third message with status 0x8 ch 2 sends 3 bytes (0x82 ...).
  - After reset, first 0x92 is sent in full.
- Rejection and masking:
  - status 0x3 -> error_out pulses one cycle, tx_wire_out stays 1, ready_out back in 2 cycles.
  - status 0xB, d1 0xBC -> data byte sent as 0x3C.
- Reset during 2nd data bit of first byte -> tx_wire_out=1 asynchronously. ready_out=1 one edge after release; next identical message sends its status byte (running status cleared).
- valid_in held high with back-to-back messages -> second accepted exactly on the cycle ready_out reasserts; no message lost or duplicated.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI transmit path.
//   - status-nibble constants for channel-voice messages
//   - MIDI_BAUD line rate
//   - msg_len(): bytes on the wire for a status nibble (0 = reject)
//   - FSM state enums for the message sequencer and the byte serializer
package midi_pkg;

  localparam int MIDI_BAUD = 31_250;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // Message sequencer: LOAD picks the first byte (running-status skip),
  // START hands it to the serializer, SEND feeds the remaining bytes.
  typedef enum logic [2:0] {
    MS_IDLE,
    MS_LOAD,
    MS_START,
    MS_SEND,
    MS_ERR
  } msg_state_e;

  // 8N1 serializer phases.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic logic [1:0] msg_len(input logic [3:0] status);
    case (status)
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: msg_len = 2'd3;
      PROG, CHAN_AT:                         msg_len = 2'd2;
      default:                               msg_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer, LSB first, BIT_CYCLES clocks per bit.
// Ports:
//   clk_in, rst_in   clock, async active-low reset
//   byte_in/valid_in byte request; taken when valid_in && ready_out
//   ready_out        idle, or in the last cycle of a stop bit so the next
//                    start bit follows with no gap
//   done_out         high in the last cycle of the stop bit
//   tx_out           registered line output, idle high
module uart_byte_tx
  import midi_pkg::*;
#(
  parameter int BIT_CYCLES = 3200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       done_out,
  output logic       tx_out
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  tx_state_e      r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           w_bit_end, w_take;

  assign w_bit_end = (r_cnt == LAST);
  assign done_out  = (r_state == TX_STOP) && w_bit_end;
  assign ready_out = (r_state == TX_IDLE) || done_out;
  assign w_take    = valid_in && ready_out;
  assign tx_out    = r_tx;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TX_IDLE:  if (w_take) w_state_nxt = TX_START;
      TX_START: if (w_bit_end) w_state_nxt = TX_DATA;
      TX_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_nxt = TX_STOP;
      TX_STOP:  if (w_bit_end) w_state_nxt = w_take ? TX_START : TX_IDLE;
      default:  w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_shift <= byte_in;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_tx    <= 1'b0;
      end else begin
        case (r_state)
          TX_IDLE: begin
            r_cnt <= '0;
            r_tx  <= 1'b1;
          end
          TX_START: begin
            r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            if (w_bit_end) r_tx <= r_shift[0];
          end
          TX_DATA: begin
            r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            if (w_bit_end) begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              // after bit 7 the line goes to the stop level
              r_tx    <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
            end
          end
          TX_STOP: begin
            r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            r_tx  <= 1'b1;
          end
          default: r_tx <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_writer.sv
// MIDI transmit path: one channel-voice message per handshake, sent as
// 8N1 frames at BAUD_RATE with optional running-status compression.
// Ports:
//   clk_in, rst_in            clock, async active-low reset
//   status_in, channel_in     message type nibble and channel
//   data_byte1_in/2_in        data bytes (bit 7 forced to 0 on the wire)
//   valid_in / ready_out      request handshake
//   tx_wire_out               UART line, idle high
//   busy_out                  high while a message is being sent
//   error_out                 one-cycle pulse on a rejected status nibble
module midi_writer
  import midi_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD_RATE      = MIDI_BAUD,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] status_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] data_byte1_in,
  input  logic [7:0] data_byte2_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       error_out
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;

  msg_state_e      r_state, w_state_nxt;
  logic [2:0][7:0] r_bytes;     // [0]=status, [1]/[2]=data
  logic [1:0]      r_idx;       // byte currently on the wire
  logic [1:0]      r_last_idx;  // index of the final byte
  logic [7:0]      r_rs;        // last status byte sent
  logic            r_rs_vld;
  logic            r_live;      // holds ready low until the first edge out of reset
  logic            w_accept, w_rs_hit;
  logic            w_tx_vld, w_tx_rdy, w_tx_done;
  logic [7:0]      w_tx_byte;
  logic [1:0]      w_len;

  assign w_len     = msg_len(status_in);
  assign ready_out = r_live && (r_state == MS_IDLE);
  assign w_accept  = valid_in && ready_out;
  assign busy_out  = (r_state == MS_LOAD) || (r_state == MS_START) || (r_state == MS_SEND);
  assign error_out = (r_state == MS_ERR);
  assign w_rs_hit  = RUNNING_STATUS && r_rs_vld && (r_rs == r_bytes[0]);

  always_comb begin
    w_state_nxt = r_state;
    w_tx_vld    = 1'b0;
    w_tx_byte   = r_bytes[r_idx];
    case (r_state)
      MS_IDLE:  if (w_accept) w_state_nxt = (w_len == 2'd0) ? MS_ERR : MS_LOAD;
      MS_LOAD:  w_state_nxt = MS_START;
      MS_START: begin
        w_tx_vld = 1'b1;
        if (w_tx_rdy) w_state_nxt = MS_SEND;
      end
      MS_SEND: begin
        if (w_tx_done) begin
          if (r_idx == r_last_idx) begin
            w_state_nxt = MS_IDLE;
          end else begin
            // next byte is handed over in the last stop cycle: no gap
            w_tx_vld  = 1'b1;
            w_tx_byte = r_bytes[r_idx + 2'd1];
          end
        end
      end
      MS_ERR:   w_state_nxt = MS_IDLE;
      default:  w_state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= MS_IDLE;
      r_live     <= 1'b0;
      r_bytes    <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_rs       <= '0;
      r_rs_vld   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_bytes[0] <= {status_in, channel_in};
        r_bytes[1] <= data_byte1_in & 8'h7F;
        r_bytes[2] <= data_byte2_in & 8'h7F;
        r_last_idx <= w_len - 2'd1;
      end
      if (r_state == MS_LOAD) begin
        if (w_rs_hit) begin
          r_idx <= 2'd1;
        end else begin
          r_idx    <= 2'd0;
          r_rs     <= r_bytes[0];
          r_rs_vld <= 1'b1;
        end
      end
      if (r_state == MS_SEND && w_tx_done && r_idx != r_last_idx)
        r_idx <= r_idx + 2'd1;
    end
  end

  uart_byte_tx #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_tx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .byte_in   (w_tx_byte),
    .valid_in  (w_tx_vld),
    .ready_out (w_tx_rdy),
    .done_out  (w_tx_done),
    .tx_out    (tx_wire_out)
  );

endmodule

// File: tb/tb_midi_writer.sv
module tb_midi_writer;

  // 16 clocks per bit keeps the run short while exercising the same logic
  localparam int BITC  = 16;
  localparam int FRAME = 10 * BITC;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [3:0] status_in, channel_in;
  logic [7:0] data_byte1_in, data_byte2_in;
  logic       valid_in;
  logic       ready_out, tx_wire_out, busy_out, error_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int fr_err = 0;
  int width_err = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  midi_writer #(
    .CLK_FREQ       (BITC * 31_250),
    .BAUD_RATE      (31_250),
    .RUNNING_STATUS (1'b1)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .status_in     (status_in),
    .channel_in    (channel_in),
    .data_byte1_in (data_byte1_in),
    .data_byte2_in (data_byte2_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .tx_wire_out   (tx_wire_out),
    .busy_out      (busy_out),
    .error_out     (error_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Line decoder: samples every cycle on the falling edge, requires each
  // bit to hold for exactly BITC cycles, abandons a frame on reset.
  initial begin : mon
    logic [9:0] bv;
    logic       abort;
    int         st;
    forever begin
      @(negedge clk_in);
      if (rst_in === 1'b1 && tx_wire_out === 1'b0) begin
        st = cyc;
        abort = 1'b0;
        bv = '0;
        for (int k = 0; k < 10; k++) begin
          for (int j = 0; j < BITC; j++) begin
            if (!(k == 0 && j == 0)) @(negedge clk_in);
            if (rst_in !== 1'b1) begin
              abort = 1'b1;
              break;
            end
            if (j == 0) bv[k] = tx_wire_out;
            else if (tx_wire_out !== bv[k]) width_err++;
          end
          if (abort) break;
        end
        if (!abort) begin
          if (bv[0] !== 1'b0 || bv[9] !== 1'b1) fr_err++;
          rx_q.push_back(bv[8:1]);
          rx_t.push_back(st);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] st, input logic [3:0] ch,
                      input logic [7:0] d1, input logic [7:0] d2, output int c_acc);
    int k;
    k = 0;
    while (ready_out !== 1'b1 && k < 2000) begin
      @(posedge clk_in); #1;
      k++;
    end
    if (ready_out !== 1'b1) chk("send_ready_timeout", ready_out, 1);
    status_in = st; channel_in = ch; data_byte1_in = d1; data_byte2_in = d2;
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    c_acc = cyc;
    valid_in = 1'b0;
  endtask

  // Edges from acceptance until ready is seen high; counts cycles where
  // neither ready nor busy is high.
  task automatic wait_rdy(output int n, output int gap);
    n = 0;
    gap = 0;
    do begin
      @(posedge clk_in); #1;
      n++;
      if (ready_out !== 1'b1 && busy_out !== 1'b1) gap++;
    end while (ready_out !== 1'b1 && n < 2000);
  endtask

  task automatic msg(input string tag, input logic [3:0] st, input logic [3:0] ch,
                     input logic [7:0] d1, input logic [7:0] d2, input int nb,
                     input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int cA, n, gap;
    logic [7:0] eb[3];
    eb[0] = b0; eb[1] = b1; eb[2] = b2;
    rx_q.delete(); rx_t.delete();
    send(st, ch, d1, d2, cA);
    chk({tag, "_busy"}, busy_out, 1);
    chk({tag, "_rdy_drop"}, ready_out, 0);
    wait_rdy(n, gap);
    chk({tag, "_len"}, n, nb * FRAME + 2);
    chk({tag, "_busy_gap"}, gap, 0);
    chk({tag, "_nbytes"}, rx_q.size(), nb);
    for (int k = 0; k < nb; k++)
      if (k < rx_q.size()) chk($sformatf("%s_byte%0d", tag, k), rx_q[k], eb[k]);
    if (rx_t.size() > 0) chk({tag, "_start_ofs"}, rx_t[0] - cA, 2);
  endtask

  initial begin : stim
    int cA, n, gap;
    rst_in = 1'b0; valid_in = 1'b0;
    status_in = '0; channel_in = '0; data_byte1_in = '0; data_byte2_in = '0;

    // reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tx", tx_wire_out, 1);
    chk("rst_ready", ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_error", error_out, 0);
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("ready_after_release", ready_out, 1);

    // full 3-byte and 2-byte messages
    msg("noteon", 4'h9, 4'h0, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);
    msg("prog",   4'hC, 4'h5, 8'h07, 8'hFF, 2, 8'hC5, 8'h07, 8'h00);

    // running status
    msg("rs_first", 4'h9, 4'h2, 8'h3C, 8'h40, 3, 8'h92, 8'h3C, 8'h40);
    msg("rs_skip",  4'h9, 4'h2, 8'h3E, 8'h40, 2, 8'h3E, 8'h40, 8'h00);
    msg("rs_new",   4'h8, 4'h2, 8'h40, 8'h00, 3, 8'h82, 8'h40, 8'h00);

    // rejected status nibble
    rx_q.delete(); rx_t.delete();
    send(4'h3, 4'h2, 8'h11, 8'h22, cA);
    chk("rej_error", error_out, 1);
    chk("rej_ready_low", ready_out, 0);
    chk("rej_busy", busy_out, 0);
    @(posedge clk_in); #1;
    chk("rej_error_clear", error_out, 0);
    chk("rej_ready_back", ready_out, 1);
    repeat (40) @(posedge clk_in);
    #1;
    chk("rej_no_frame", rx_q.size(), 0);
    chk("rej_line_idle", tx_wire_out, 1);
    // stored status 0x82 survives the rejection
    msg("rs_after_rej", 4'h8, 4'h2, 8'h41, 8'h00, 2, 8'h41, 8'h00, 8'h00);

    // data bit 7 masking
    msg("mask", 4'hB, 4'h1, 8'hBC, 8'h85, 3, 8'hB1, 8'h3C, 8'h05);

    // reset mid-frame: 0x90 is stored, so the frame in flight is 0x3C
    msg("pre_rst", 4'h9, 4'h0, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);
    rx_q.delete(); rx_t.delete();
    send(4'h9, 4'h0, 8'h3C, 8'h64, cA);
    repeat (39) @(posedge clk_in);   // inside data bit 1 (a 0 bit)
    #1;
    chk("mid_line_low", tx_wire_out, 0);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_line", tx_wire_out, 1);
    chk("mid_rst_ready", ready_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("mid_rst_ready_back", ready_out, 1);
    chk("mid_rst_no_frame", rx_q.size(), 0);
    msg("post_rst", 4'h9, 4'h0, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);

    // valid held high across two back-to-back messages
    rx_q.delete(); rx_t.delete();
    status_in = 4'hC; channel_in = 4'h0; data_byte1_in = 8'h10; data_byte2_in = 8'h00;
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    chk("held_acc_a", ready_out, 0);
    status_in = 4'hD; data_byte1_in = 8'h20;
    wait_rdy(n, gap);
    chk("held_len_a", n, 2 * FRAME + 2);
    @(posedge clk_in); #1;
    chk("held_acc_b_ready", ready_out, 0);
    chk("held_acc_b_busy", busy_out, 1);
    valid_in = 1'b0;
    wait_rdy(n, gap);
    chk("held_len_b", n, 2 * FRAME + 2);
    chk("held_gap", gap, 0);
    repeat (20) @(posedge clk_in);
    #1;
    chk("held_ready_idle", ready_out, 1);
    chk("held_nbytes", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      chk("held_b0", rx_q[0], 8'hC0);
      chk("held_b1", rx_q[1], 8'h10);
      chk("held_b2", rx_q[2], 8'hD0);
      chk("held_b3", rx_q[3], 8'h20);
      chk("held_b_start", rx_t[2] - rx_t[0], 2 * FRAME + 3);
    end

    chk("frame_errors", fr_err, 0);
    chk("bit_width_errors", width_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
